prog_loader_ctrl: RTL

Sequencer that owns the accumulator CPU's program-memory programming port and its run/hold control. It accepts a byte stream from a host over a valid/ready handshake and writes it into the 32-entry program memory through the datapath's AddrSel/Addrload/PRload path. It then releases the CPU and reports completion when the CPU raises Halt. It sits beside the control unit and datapath at the top level, replacing manual switch-driven programming.

---
 rtl/prog_loader_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/prog_loader_ctrl.sv
// Program-memory loader and CPU run/hold sequencer for the accumulator CPU.
// Optional checksum byte after the payload is enabled by defining LOADER_CHKSUM_EN.
module prog_loader_ctrl (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       ld_start,
  input  logic       ld_abort,
  input  logic [4:0] ld_base,
  input  logic [5:0] ld_len,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic       Halt,
  output logic       programEn,
  output logic       Addrload,
  output logic       PRload,
  output logic [4:0] AddrSel,
  output logic [7:0] PrgData,
  output logic       cpu_rst,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT_DATA,
    S_WRITE,
    S_RUN,
    S_HALTED
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] ptr_q, ptr_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] len_q, len_d;
  logic [7:0] prg_data_q, prg_data_d;
  logic       err_q, err_d;
  logic       len_ok;
`ifdef LOADER_CHKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       chk_q, chk_d;
`endif

  assign len_ok = (ld_len != 6'd0) && (ld_len <= 6'd32);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      prg_data_q <= '0;
      err_q      <= 1'b0;
`ifdef LOADER_CHKSUM_EN
      sum_q      <= '0;
      chk_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      prg_data_q <= prg_data_d;
      err_q      <= err_d;
`ifdef LOADER_CHKSUM_EN
      sum_q      <= sum_d;
      chk_q      <= chk_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    prg_data_d = prg_data_q;
    err_d      = err_q;
`ifdef LOADER_CHKSUM_EN
    sum_d      = sum_q;
    chk_d      = chk_q;
`endif
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (ld_start) begin
          if (len_ok) begin
            ptr_d   = ld_base;
            cnt_d   = '0;
            len_d   = ld_len;
            err_d   = 1'b0;
            state_d = S_ADDR;
`ifdef LOADER_CHKSUM_EN
            sum_d   = '0;
            chk_d   = 1'b0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (ld_abort) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        if (ld_abort) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (data_valid) begin
`ifdef LOADER_CHKSUM_EN
          if (chk_q) begin
            // Checksum pass: the byte is compared, never written to memory.
            chk_d = 1'b0;
            if (data_in == sum_q) begin
              state_d = S_RUN;
            end else begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            prg_data_d = data_in;
            sum_d      = sum_q + data_in;
            state_d    = S_WRITE;
          end
`else
          prg_data_d = data_in;
          state_d    = S_WRITE;
`endif
        end
      end
      S_WRITE: begin
        if (ld_abort) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          ptr_d = ptr_q + 5'd1;
          cnt_d = cnt_q + 6'd1;
          if (cnt_d == len_q) begin
`ifdef LOADER_CHKSUM_EN
            chk_d   = 1'b1;
            state_d = S_WAIT_DATA;
`else
            state_d = S_RUN;
`endif
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      S_RUN: begin
        if (Halt) state_d = S_HALTED;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    programEn  = 1'b0;
    Addrload   = 1'b0;
    PRload     = 1'b0;
    data_ready = 1'b0;
    cpu_rst    = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    AddrSel    = ptr_q;
    PrgData    = prg_data_q;
    err        = err_q;
    case (state_q)
      S_ADDR: begin
        programEn = 1'b1;
        busy      = 1'b1;
        Addrload  = 1'b1;
      end
      S_WAIT_DATA: begin
        programEn  = 1'b1;
        busy       = 1'b1;
        data_ready = 1'b1;
      end
      S_WRITE: begin
        programEn = 1'b1;
        busy      = 1'b1;
        PRload    = 1'b1;
      end
      S_RUN:    cpu_rst = 1'b0;
      S_HALTED: done    = 1'b1;
      default: ;
    endcase
  end

endmodule
